// File: rtl/compare_seq_accum.sv
// Multi-lane, multi-digit sign-code comparator: reduces framed beats of digit signs to one result per lane.
// Optional beat counter output (out_beats) is enabled by defining COMPARE_BEAT_CNT_EN.
module compare_seq_accum #(
    parameter int LANES     = 4,
    parameter int DIGITS    = 4,
    parameter int MSD_FIRST = 0,
    parameter int CNT_W     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_first,
    input  logic                      in_last,
    input  logic [LANES*DIGITS*2-1:0] in_sign,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*2-1:0]        out_sign,
    output logic [LANES-1:0]          out_err,
`ifdef COMPARE_BEAT_CNT_EN
    output logic [CNT_W-1:0]          out_beats,
`endif
    output logic                      busy
);

    typedef enum logic {
        S_IDLE,
        S_ACCUM
    } state_t;

    state_t               r_state;
    logic [LANES*2-1:0]   r_acc;
    logic [LANES-1:0]     r_err;
    logic                 r_outValid;
    logic [LANES*2-1:0]   r_outSign;
    logic [LANES-1:0]     r_outErr;

    logic                 w_accept;
    logic                 w_firstBeat;
    logic [LANES*2-1:0]   w_beatSign;
    logic [LANES-1:0]     w_beatErr;
    logic [LANES*2-1:0]   w_accNext;
    logic [LANES-1:0]     w_errNext;
    logic [LANES*2-1:0]   w_resultSign;

    // The output slot can take a new result when empty or being drained this cycle.
    assign in_ready    = !r_outValid || out_ready;
    assign w_accept    = in_valid && in_ready;
    assign w_firstBeat = (r_state == S_IDLE) || in_first;

    // Per lane: highest-index decisive digit wins; undefined digits only raise the error flag.
    always_comb begin
        w_beatSign   = {LANES{2'b01}};
        w_beatErr    = '0;
        w_accNext    = {LANES{2'b01}};
        w_errNext    = '0;
        w_resultSign = {LANES{2'b01}};
        for (int l = 0; l < LANES; l++) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (in_sign[(l*DIGITS+d)*2 +: 2] == 2'b11) begin
                    w_beatErr[l] = 1'b1;
                end else if (in_sign[(l*DIGITS+d)*2 +: 2] != 2'b01) begin
                    w_beatSign[l*2 +: 2] = in_sign[(l*DIGITS+d)*2 +: 2];
                end
            end
            w_accNext[l*2 +: 2] = w_firstBeat ? 2'b01 : r_acc[l*2 +: 2];
            if (MSD_FIRST != 0) begin
                if (w_accNext[l*2 +: 2] == 2'b01) begin
                    w_accNext[l*2 +: 2] = w_beatSign[l*2 +: 2];
                end
            end else begin
                if (w_beatSign[l*2 +: 2] != 2'b01) begin
                    w_accNext[l*2 +: 2] = w_beatSign[l*2 +: 2];
                end
            end
            w_errNext[l]           = (!w_firstBeat && r_err[l]) || w_beatErr[l];
            w_resultSign[l*2 +: 2] = w_errNext[l] ? 2'b11 : w_accNext[l*2 +: 2];
        end
    end

    // Frame FSM plus the registered result slot; a consume and a reload on the same edge keep out_valid high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_acc      <= {LANES{2'b01}};
            r_err      <= '0;
            r_outValid <= 1'b0;
            r_outSign  <= {LANES{2'b01}};
            r_outErr   <= '0;
        end else begin
            if (r_outValid && out_ready) begin
                r_outValid <= 1'b0;
            end
            if (w_accept) begin
                r_acc <= w_accNext;
                r_err <= w_errNext;
                if (in_last) begin
                    r_outValid <= 1'b1;
                    r_outSign  <= w_resultSign;
                    r_outErr   <= w_errNext;
                    r_state    <= S_IDLE;
                end else begin
                    r_state    <= S_ACCUM;
                end
            end
        end
    end

    assign out_valid = r_outValid;
    assign out_sign  = r_outSign;
    assign out_err   = r_outErr;
    assign busy      = (r_state == S_ACCUM);

`ifdef COMPARE_BEAT_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_outBeats;
    logic [CNT_W-1:0] w_cntNext;

    // Saturating count of beats in the current frame, restarted by any first beat.
    always_comb begin
        w_cntNext = CNT_W'(1);
        if (!w_firstBeat) begin
            w_cntNext = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_outBeats <= '0;
        end else if (w_accept) begin
            r_cnt <= w_cntNext;
            if (in_last) begin
                r_outBeats <= w_cntNext;
            end
        end
    end

    assign out_beats = r_outBeats;
`endif

endmodule

// File: tb/tb_compare_seq_accum.sv
// Directed bench for compare_seq_accum: LSD-first and MSD-first instances share stimulus and
// are checked every cycle against a frame-level model, plus hand-computed literal checks.
module tb_compare_seq_accum;

    localparam int LANES  = 4;
    localparam int DIGITS = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_first;
    logic        in_last;
    logic [31:0] in_sign;
    logic        out_ready;

    logic        inReady0, inReady1;
    logic        outValid0, outValid1;
    logic [7:0]  outSign0, outSign1;
    logic [3:0]  outErr0, outErr1;
    logic        busy0, busy1;
`ifdef COMPARE_BEAT_CNT_EN
    logic [1:0]  outBeats0, outBeats1;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    compare_seq_accum #(.LANES(LANES), .DIGITS(DIGITS), .MSD_FIRST(0), .CNT_W(2)) dut0 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(inReady0), .in_first(in_first), .in_last(in_last),
        .in_sign(in_sign),
        .out_valid(outValid0), .out_ready(out_ready), .out_sign(outSign0), .out_err(outErr0),
`ifdef COMPARE_BEAT_CNT_EN
        .out_beats(outBeats0),
`endif
        .busy(busy0)
    );

    compare_seq_accum #(.LANES(LANES), .DIGITS(DIGITS), .MSD_FIRST(1), .CNT_W(2)) dut1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(inReady1), .in_first(in_first), .in_last(in_last),
        .in_sign(in_sign),
        .out_valid(outValid1), .out_ready(out_ready), .out_sign(outSign1), .out_err(outErr1),
`ifdef COMPARE_BEAT_CNT_EN
        .out_beats(outBeats1),
`endif
        .busy(busy1)
    );

    // Frame-level model: collect the beats of the open frame, evaluate the result when the frame ends.
    logic [31:0] frameQ[$];
    bit          started  = 0;
    bit          expValid = 0;
    bit          expBusy  = 0;
    logic [7:0]  expSign0 = 8'h55;
    logic [7:0]  expSign1 = 8'h55;
    logic [3:0]  expErr   = 4'h0;
    int          expBeats = 0;

    function automatic logic [1:0] beatCode(logic [31:0] s, int lane);
        logic [1:0] c = 2'b01;
        for (int d = 0; d < DIGITS; d++) begin
            if (s[(lane*DIGITS+d)*2 +: 2] == 2'b10 || s[(lane*DIGITS+d)*2 +: 2] == 2'b00)
                c = s[(lane*DIGITS+d)*2 +: 2];
        end
        return c;
    endfunction

    function automatic bit laneHasUndef(logic [31:0] s, int lane);
        for (int d = 0; d < DIGITS; d++)
            if (s[(lane*DIGITS+d)*2 +: 2] == 2'b11) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [1:0] frameResult(bit msdFirst, int lane);
        logic [1:0] r = 2'b01;
        bit found = 0;
        bit err = 0;
        foreach (frameQ[i]) begin
            if (laneHasUndef(frameQ[i], lane)) err = 1;
            if (beatCode(frameQ[i], lane) != 2'b01) begin
                if (!msdFirst || !found) r = beatCode(frameQ[i], lane);
                found = 1;
            end
        end
        return err ? 2'b11 : r;
    endfunction

    always @(posedge clk) begin
        bit canTake;
        if (reset) begin
            started  = 1;
            frameQ.delete();
            expValid = 0;
            expBusy  = 0;
            expSign0 = 8'h55;
            expSign1 = 8'h55;
            expErr   = 4'h0;
            expBeats = 0;
        end else begin
            canTake = !expValid || out_ready;
            if (expValid && out_ready) expValid = 0;
            if (in_valid && canTake) begin
                if (!expBusy || in_first) frameQ.delete();
                frameQ.push_back(in_sign);
                if (in_last) begin
                    for (int l = 0; l < LANES; l++) begin
                        expSign0[l*2 +: 2] = frameResult(0, l);
                        expSign1[l*2 +: 2] = frameResult(1, l);
                        expErr[l] = 1'b0;
                        foreach (frameQ[i]) if (laneHasUndef(frameQ[i], l)) expErr[l] = 1'b1;
                    end
                    expBeats = (frameQ.size() > 3) ? 3 : frameQ.size();
                    expValid = 1;
                    expBusy  = 0;
                end else begin
                    expBusy = 1;
                end
            end
        end
    end

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            checkOutput("in_ready0", 32'(inReady0), 32'(!expValid || out_ready));
            checkOutput("in_ready1", 32'(inReady1), 32'(!expValid || out_ready));
            checkOutput("out_valid0", 32'(outValid0), 32'(expValid));
            checkOutput("out_valid1", 32'(outValid1), 32'(expValid));
            checkOutput("busy0", 32'(busy0), 32'(expBusy));
            checkOutput("busy1", 32'(busy1), 32'(expBusy));
            checkOutput("out_sign0", 32'(outSign0), 32'(expSign0));
            checkOutput("out_sign1", 32'(outSign1), 32'(expSign1));
            checkOutput("out_err0", 32'(outErr0), 32'(expErr));
            checkOutput("out_err1", 32'(outErr1), 32'(expErr));
`ifdef COMPARE_BEAT_CNT_EN
            checkOutput("out_beats0", 32'(outBeats0), 32'(expBeats));
            checkOutput("out_beats1", 32'(outBeats1), 32'(expBeats));
`endif
        end
    end

    function automatic logic [31:0] laneSign(int lane, logic [7:0] digits);
        logic [31:0] s = 32'h5555_5555;
        s[lane*8 +: 8] = digits;
        return s;
    endfunction

    task automatic applyStimulus(input logic first, input logic last, input logic [31:0] sign);
        in_valid = 1'b1;
        in_first = first;
        in_last  = last;
        in_sign  = sign;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        in_sign   = 32'h5555_5555;
        out_ready = 1'b1;
        idleCycles(2);
        reset = 1'b0;
        checkOutput("reset sign", 32'(outSign0), 32'h55);
        checkOutput("reset valid", 32'(outValid0), 32'h0);

        // Single beat: lane0 d3..d0 = 01,01,10,00 -> 10
        applyStimulus(1, 1, laneSign(0, 8'b01011000));
        checkOutput("single valid", 32'(outValid0), 32'h1);
        checkOutput("single sign lsd", 32'(outSign0), 32'h56);
        checkOutput("single sign msd", 32'(outSign1), 32'h56);

        // Three beats 10, 00, 01 with a gap after beat 1
        applyStimulus(1, 0, laneSign(0, 8'b01010110));
        checkOutput("3b busy1", 32'(busy0), 32'h1);
        idleCycles(1);
        checkOutput("3b gap busy", 32'(busy0), 32'h1);
        applyStimulus(0, 0, laneSign(0, 8'b01010100));
        checkOutput("3b valid before last", 32'(outValid0), 32'h0);
        applyStimulus(0, 1, 32'h5555_5555);
        checkOutput("3b valid", 32'(outValid0), 32'h1);
        checkOutput("3b busy done", 32'(busy0), 32'h0);
        checkOutput("3b lsd", 32'(outSign0), 32'h54);
        checkOutput("3b msd", 32'(outSign1), 32'h56);
        idleCycles(1);
        checkOutput("3b valid drop", 32'(outValid0), 32'h0);

        // Beats 01, 01, 00 -> 00 in both orders
        applyStimulus(1, 0, 32'h5555_5555);
        applyStimulus(0, 0, 32'h5555_5555);
        applyStimulus(0, 1, laneSign(0, 8'b01010100));
        checkOutput("late lsd", 32'(outSign0), 32'h54);
        checkOutput("late msd", 32'(outSign1), 32'h54);

        // Undefined digit in lane1, beat 2 of 3
        applyStimulus(1, 0, laneSign(1, 8'b10101010));
        applyStimulus(0, 0, laneSign(1, 8'b10101110));
        applyStimulus(0, 1, laneSign(1, 8'b10101010));
        checkOutput("undef sign", 32'(outSign0), 32'h5D);
        checkOutput("undef err", 32'(outErr0), 32'h2);
        applyStimulus(1, 1, 32'h5555_5555);
        checkOutput("err cleared", 32'(outErr0), 32'h0);
        checkOutput("clean sign", 32'(outSign1), 32'h55);
        idleCycles(1);

        // Backpressure: hold result, stall next last beat, then consume and reload together
        out_ready = 1'b0;
        applyStimulus(1, 1, laneSign(2, 8'b01010100));
        checkOutput("bp first result", 32'(outSign0), 32'h45);
        in_valid = 1'b1;
        in_first = 1'b1;
        in_last  = 1'b1;
        in_sign  = laneSign(3, 8'b10010101);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp in_ready", 32'(inReady0), 32'h0);
            checkOutput("bp hold sign", 32'(outSign0), 32'h45);
            checkOutput("bp hold valid", 32'(outValid0), 32'h1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("bp reload valid", 32'(outValid0), 32'h1);
        checkOutput("bp reload sign", 32'(outSign1), 32'h95);
        idleCycles(1);

        // Restart mid-frame discards earlier beats
        applyStimulus(1, 0, laneSign(0, 8'b01010100));
        applyStimulus(0, 0, laneSign(0, 8'b01010100));
        applyStimulus(1, 0, laneSign(0, 8'b01010110));
        applyStimulus(0, 1, 32'h5555_5555);
        checkOutput("restart lsd", 32'(outSign0), 32'h56);
        checkOutput("restart msd", 32'(outSign1), 32'h56);

        // Reset while accumulating discards the frame
        applyStimulus(1, 0, laneSign(0, 8'b01010110));
        checkOutput("pre-reset busy", 32'(busy0), 32'h1);
        reset = 1'b1;
        idleCycles(1);
        reset = 1'b0;
        checkOutput("reset busy", 32'(busy1), 32'h0);
        checkOutput("reset out_valid", 32'(outValid1), 32'h0);
        checkOutput("reset out_sign", 32'(outSign1), 32'h55);
        applyStimulus(0, 1, laneSign(0, 8'b01010100));
        checkOutput("post-reset msd", 32'(outSign1), 32'h54);

        // Five-beat frame
        applyStimulus(1, 0, 32'h5555_5555);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 32'h5555_5555);
        applyStimulus(0, 1, 32'h5555_5555);
        checkOutput("5b sign", 32'(outSign0), 32'h55);
`ifdef COMPARE_BEAT_CNT_EN
        checkOutput("5b beats sat", 32'(outBeats0), 32'h3);
`endif
        idleCycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
